// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM with retire counter and illegal-op flag
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  output logic             pc_write,
  output logic             ir_write,
  output logic [1:0]       pc_sel,
  output logic             reg_write,
  output logic [1:0]       rf_wsel,
  output logic [1:0]       rf_dsel,
  output logic             mem_write,
  output logic [3:0]       alu_op,
  output logic [1:0]       alu_bsel,
  output logic [2:0]       state,
  output logic             inst_done,
  output logic [CNT_W-1:0] retired,
  output logic             ill_inst
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_RALU, C_JR, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL
  } cls_t;

  localparam logic [3:0] A_AND = 4'd0, A_OR = 4'd1, A_XOR = 4'd2, A_NOR = 4'd3,
                         A_ADD = 4'd4, A_SUB = 4'd5, A_SLT = 4'd6, A_SLL = 4'd7,
                         A_SRL = 4'd8, A_LUI = 4'd9;
  localparam logic [1:0] B_RT = 2'd0, B_SEXT = 2'd1, B_ZEXT = 2'd2;

  function automatic cls_t classify(input logic [5:0] o, input logic [5:0] f);
    cls_t c;
    c = C_ILL;
    case (o)
      6'b000000: begin
        case (f)
          6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
          6'b100111, 6'b101010, 6'b000000, 6'b000010: c = C_RALU;
          6'b001000: c = C_JR;
          default:   c = C_ILL;
        endcase
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111: c = C_IALU;
      6'b100011: c = C_LW;
      6'b101011: c = C_SW;
      6'b000100: c = C_BEQ;
      6'b000101: c = C_BNE;
      6'b000010: c = C_J;
      6'b000011: c = C_JAL;
      default:   c = C_ILL;
    endcase
    return c;
  endfunction

  // Returns {alu_op, alu_bsel}; instructions without an ALU role map to AND/rt.
  function automatic logic [5:0] alu_map(input logic [5:0] o, input logic [5:0] f);
    logic [5:0] m;
    m = {A_AND, B_RT};
    case (o)
      6'b000000: begin
        case (f)
          6'b100000: m = {A_ADD, B_RT};
          6'b100010: m = {A_SUB, B_RT};
          6'b100100: m = {A_AND, B_RT};
          6'b100101: m = {A_OR,  B_RT};
          6'b100110: m = {A_XOR, B_RT};
          6'b100111: m = {A_NOR, B_RT};
          6'b101010: m = {A_SLT, B_RT};
          6'b000000: m = {A_SLL, B_RT};
          6'b000010: m = {A_SRL, B_RT};
          default:   m = {A_AND, B_RT};
        endcase
      end
      6'b001000:            m = {A_ADD, B_SEXT};
      6'b001100:            m = {A_AND, B_ZEXT};
      6'b001101:            m = {A_OR,  B_ZEXT};
      6'b001110:            m = {A_XOR, B_ZEXT};
      6'b001111:            m = {A_LUI, B_ZEXT};
      6'b100011, 6'b101011: m = {A_ADD, B_SEXT};
      6'b000100, 6'b000101: m = {A_SUB, B_RT};
      default:              m = {A_AND, B_RT};
    endcase
    return m;
  endfunction

  state_t     state_q, state_d;
  logic [5:0] op_q, func_q;
  cls_t       cls_live, cls_q;
  logic [3:0] aop_q;
  logic [1:0] bsel_q;

  // ID decides on the live fetch fields; later states use the copy taken at the end of ID.
  assign cls_live        = classify(op, func);
  assign cls_q           = classify(op_q, func_q);
  assign {aop_q, bsel_q} = alu_map(op_q, func_q);
  assign state           = state_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IF;
      op_q     <= '0;
      func_q   <= '0;
      retired  <= '0;
      ill_inst <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) begin
        op_q   <= op;
        func_q <= func;
        if (cls_live == C_ILL) ill_inst <= 1'b1;
      end
      if (inst_done) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    pc_sel    = 2'd0;
    reg_write = 1'b0;
    rf_wsel   = 2'd0;
    rf_dsel   = 2'd0;
    mem_write = 1'b0;
    alu_op    = 4'd0;
    alu_bsel  = 2'd0;
    inst_done = 1'b0;
    state_d   = S_IF;
    case (state_q)
      S_IF: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        case (cls_live)
          C_ILL: state_d = S_IF;
          C_J: begin
            pc_write  = 1'b1;
            pc_sel    = 2'd2;
            inst_done = 1'b1;
            state_d   = S_IF;
          end
          C_JAL: begin
            pc_write = 1'b1;
            pc_sel   = 2'd2;
            state_d  = S_WB;
          end
          default: state_d = S_EX;
        endcase
      end
      S_EX: begin
        alu_op   = aop_q;
        alu_bsel = bsel_q;
        case (cls_q)
          C_RALU, C_IALU: state_d = S_WB;
          C_LW, C_SW:     state_d = S_MEM;
          C_BEQ, C_BNE: begin
            pc_write  = (cls_q == C_BEQ) ? zero : ~zero;
            pc_sel    = 2'd1;
            inst_done = 1'b1;
            state_d   = S_IF;
          end
          C_JR: begin
            pc_write  = 1'b1;
            pc_sel    = 2'd3;
            inst_done = 1'b1;
            state_d   = S_IF;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        alu_op   = aop_q;
        alu_bsel = bsel_q;
        if (cls_q == C_SW) begin
          mem_write = 1'b1;
          inst_done = 1'b1;
          state_d   = S_IF;
        end else if (cls_q == C_LW) begin
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end
      S_WB: begin
        alu_op    = aop_q;
        alu_bsel  = bsel_q;
        reg_write = 1'b1;
        inst_done = 1'b1;
        state_d   = S_IF;
        case (cls_q)
          C_IALU:  begin rf_wsel = 2'd1; rf_dsel = 2'd0; end
          C_LW:    begin rf_wsel = 2'd1; rf_dsel = 2'd1; end
          C_JAL:   begin rf_wsel = 2'd2; rf_dsel = 2'd2; end
          default: begin rf_wsel = 2'd0; rf_dsel = 2'd0; end
        endcase
      end
      default: state_d = S_IF;
    endcase
    // Holding reset silences every datapath control, including mid-instruction.
    if (!rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      pc_sel    = 2'd0;
      reg_write = 1'b0;
      rf_wsel   = 2'd0;
      rf_dsel   = 2'd0;
      mem_write = 1'b0;
      alu_op    = 4'd0;
      alu_bsel  = 2'd0;
      inst_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op, func;
  logic        zero;

  logic        pc_write, ir_write, reg_write, mem_write, inst_done, ill_inst;
  logic [1:0]  pc_sel, rf_wsel, rf_dsel, alu_bsel;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] retired;

  logic        d2_pc_write, d2_ir_write, d2_reg_write, d2_mem_write, d2_inst_done, d2_ill_inst;
  logic [1:0]  d2_pc_sel, d2_rf_wsel, d2_rf_dsel, d2_alu_bsel;
  logic [3:0]  d2_alu_op;
  logic [2:0]  d2_state;
  logic [1:0]  d2_retired;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero),
    .pc_write(pc_write), .ir_write(ir_write), .pc_sel(pc_sel), .reg_write(reg_write),
    .rf_wsel(rf_wsel), .rf_dsel(rf_dsel), .mem_write(mem_write), .alu_op(alu_op),
    .alu_bsel(alu_bsel), .state(state), .inst_done(inst_done), .retired(retired),
    .ill_inst(ill_inst)
  );

  mips_multicycle_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero),
    .pc_write(d2_pc_write), .ir_write(d2_ir_write), .pc_sel(d2_pc_sel), .reg_write(d2_reg_write),
    .rf_wsel(d2_rf_wsel), .rf_dsel(d2_rf_dsel), .mem_write(d2_mem_write), .alu_op(d2_alu_op),
    .alu_bsel(d2_alu_bsel), .state(d2_state), .inst_done(d2_inst_done), .retired(d2_retired),
    .ill_inst(d2_ill_inst)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic       irw;
    logic [1:0] pcs;
    logic       rw;
    logic [1:0] wsel;
    logic [1:0] dsel;
    logic       mw;
    logic [3:0] aop;
    logic [1:0] bsel;
    logic       done;
  } exp_t;

  logic [19:0] obs1, obs2;
  assign obs1 = {state, pc_write, ir_write, pc_sel, reg_write, rf_wsel, rf_dsel,
                 mem_write, alu_op, alu_bsel, inst_done};
  assign obs2 = {d2_state, d2_pc_write, d2_ir_write, d2_pc_sel, d2_reg_write, d2_rf_wsel,
                 d2_rf_dsel, d2_mem_write, d2_alu_op, d2_alu_bsel, d2_inst_done};

  localparam int K_ILL = 0, K_ALU_R = 1, K_ALU_I = 2, K_LW = 3, K_SW = 4, K_BEQ = 5,
                 K_BNE = 6, K_J = 7, K_JAL = 8, K_JR = 9;

  typedef struct {
    logic [5:0] op;
    logic [5:0] func;
    bit         is_r;
    int         kind;
    logic [3:0] aop;
    logic [1:0] bsel;
  } row_t;

  row_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_ret = 0;
  bit   model_ill = 1'b0;

  task automatic add_row(input logic [5:0] o, input logic [5:0] f, input bit r,
                         input int k, input logic [3:0] a, input logic [1:0] b);
    row_t x;
    x.op = o; x.func = f; x.is_r = r; x.kind = k; x.aop = a; x.bsel = b;
    tbl.push_back(x);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic lookup(input logic [5:0] o, input logic [5:0] f,
                        output int k, output logic [3:0] a, output logic [1:0] b);
    k = K_ILL; a = 4'd0; b = 2'd0;
    foreach (tbl[i]) begin
      if (tbl[i].op == o && (!tbl[i].is_r || tbl[i].func == f)) begin
        k = tbl[i].kind; a = tbl[i].aop; b = tbl[i].bsel;
      end
    end
  endtask

  // Runs one instruction from IF; abort_at >= 0 pulls reset low in that cycle instead.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int abort_at);
    exp_t q[$];
    exp_t e;
    int k;
    logic [3:0] a;
    logic [1:0] b;
    lookup(o, f, k, a, b);

    e = '0; e.st = 3'd0; e.pcw = 1'b1; e.irw = 1'b1;
    q.push_back(e);
    e = '0; e.st = 3'd1;
    if (k == K_J)   begin e.pcw = 1'b1; e.pcs = 2'd2; e.done = 1'b1; end
    if (k == K_JAL) begin e.pcw = 1'b1; e.pcs = 2'd2; end
    q.push_back(e);
    if (k inside {K_ALU_R, K_ALU_I, K_LW, K_SW, K_BEQ, K_BNE, K_JR}) begin
      e = '0; e.st = 3'd2; e.aop = a; e.bsel = b;
      if (k == K_BEQ) begin e.pcw = z;  e.pcs = 2'd1; e.done = 1'b1; end
      if (k == K_BNE) begin e.pcw = !z; e.pcs = 2'd1; e.done = 1'b1; end
      if (k == K_JR)  begin e.pcw = 1'b1; e.pcs = 2'd3; e.done = 1'b1; end
      q.push_back(e);
    end
    if (k inside {K_LW, K_SW}) begin
      e = '0; e.st = 3'd3; e.aop = a; e.bsel = b;
      if (k == K_SW) begin e.mw = 1'b1; e.done = 1'b1; end
      q.push_back(e);
    end
    if (k inside {K_ALU_R, K_ALU_I, K_LW, K_JAL}) begin
      e = '0; e.st = 3'd4; e.aop = a; e.bsel = b; e.rw = 1'b1; e.done = 1'b1;
      if (k == K_ALU_I) begin e.wsel = 2'd1; e.dsel = 2'd0; end
      if (k == K_LW)    begin e.wsel = 2'd1; e.dsel = 2'd1; end
      if (k == K_JAL)   begin e.wsel = 2'd2; e.dsel = 2'd2; end
      q.push_back(e);
    end

    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b1;
      if (i < 2) begin
        op = o; func = f;
      end else begin
        op = 6'($urandom); func = 6'($urandom);
      end
      zero = (i == 2) ? z : 1'($urandom);
      e = q[i];
      if (i == abort_at) begin
        rst = 1'b1 ^ 1'b1;
        e = '0; e.st = q[i].st;
      end
      #1;
      check($sformatf("ctrl op=%b f=%b cyc=%0d", o, f, i), 32'(obs1), 32'(e));
      check($sformatf("ctrl2 op=%b f=%b cyc=%0d", o, f, i), 32'(obs2), 32'(e));
      check("retired", retired, 32'(model_ret));
      check("retired_w2", 32'(d2_retired), 32'(model_ret % 4));
      check("ill_inst", 32'(ill_inst), 32'(model_ill));
      if (i == abort_at) begin
        model_ret = 0;
        model_ill = 1'b0;
        break;
      end
      if (e.done) model_ret++;
      if (i == 1 && k == K_ILL) model_ill = 1'b1;
    end
  endtask

  initial begin
    logic [5:0] ro, rf;
    rst = 1'b0; op = '0; func = '0; zero = 1'b0;

    add_row(6'b000000, 6'b100000, 1, K_ALU_R, 4'd4, 2'd0);
    add_row(6'b000000, 6'b100010, 1, K_ALU_R, 4'd5, 2'd0);
    add_row(6'b000000, 6'b100100, 1, K_ALU_R, 4'd0, 2'd0);
    add_row(6'b000000, 6'b100101, 1, K_ALU_R, 4'd1, 2'd0);
    add_row(6'b000000, 6'b100110, 1, K_ALU_R, 4'd2, 2'd0);
    add_row(6'b000000, 6'b100111, 1, K_ALU_R, 4'd3, 2'd0);
    add_row(6'b000000, 6'b101010, 1, K_ALU_R, 4'd6, 2'd0);
    add_row(6'b000000, 6'b000000, 1, K_ALU_R, 4'd7, 2'd0);
    add_row(6'b000000, 6'b000010, 1, K_ALU_R, 4'd8, 2'd0);
    add_row(6'b000000, 6'b001000, 1, K_JR,    4'd0, 2'd0);
    add_row(6'b001000, 6'b000000, 0, K_ALU_I, 4'd4, 2'd1);
    add_row(6'b001100, 6'b000000, 0, K_ALU_I, 4'd0, 2'd2);
    add_row(6'b001101, 6'b000000, 0, K_ALU_I, 4'd1, 2'd2);
    add_row(6'b001110, 6'b000000, 0, K_ALU_I, 4'd2, 2'd2);
    add_row(6'b001111, 6'b000000, 0, K_ALU_I, 4'd9, 2'd2);
    add_row(6'b100011, 6'b000000, 0, K_LW,    4'd4, 2'd1);
    add_row(6'b101011, 6'b000000, 0, K_SW,    4'd4, 2'd1);
    add_row(6'b000100, 6'b000000, 0, K_BEQ,   4'd5, 2'd0);
    add_row(6'b000101, 6'b000000, 0, K_BNE,   4'd5, 2'd0);
    add_row(6'b000010, 6'b000000, 0, K_J,     4'd0, 2'd0);
    add_row(6'b000011, 6'b000000, 0, K_JAL,   4'd0, 2'd0);

    repeat (2) @(negedge clk);
    #1;
    check("reset_ctrl", 32'(obs1), 32'd0);
    check("reset_retired", retired, 32'd0);
    check("reset_ill", 32'(ill_inst), 32'd0);

    run_instr(6'b000000, 6'b100000, 1'b0, -1);
    run_instr(6'b100011, 6'b010101, 1'b1, -1);
    run_instr(6'b101011, 6'b000000, 1'b0, -1);
    run_instr(6'b000100, 6'b000000, 1'b1, -1);
    run_instr(6'b000100, 6'b000000, 1'b0, -1);
    run_instr(6'b000101, 6'b000000, 1'b1, -1);
    run_instr(6'b000101, 6'b000000, 1'b0, -1);
    run_instr(6'b000011, 6'b000000, 1'b0, -1);
    run_instr(6'b000010, 6'b000000, 1'b0, -1);
    run_instr(6'b111111, 6'b000000, 1'b0, -1);
    run_instr(6'b000000, 6'b100000, 1'b0, -1);
    run_instr(6'b000000, 6'b000000, 1'b0, -1);
    run_instr(6'b000000, 6'b001000, 1'b0, -1);
    run_instr(6'b001111, 6'b000000, 1'b0, -1);
    run_instr(6'b000000, 6'b111111, 1'b0, -1);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        int r;
        r  = $urandom_range(0, tbl.size() - 1);
        ro = tbl[r].op;
        rf = tbl[r].is_r ? tbl[r].func : 6'($urandom);
      end else begin
        ro = 6'($urandom);
        rf = 6'($urandom);
      end
      run_instr(ro, rf, 1'($urandom), -1);
    end

    run_instr(6'b100011, 6'b000000, 1'b0, 2);
    for (int n = 0; n < 5; n++) run_instr(6'b000000, 6'b100000, 1'b0, -1);
    @(negedge clk);
    #1;
    check("wrap_w2_after5", 32'(d2_retired), 32'd1);
    check("retired_after5", retired, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
